// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage <-> multiply/divide unit bundle.
//   start/function_in/rs1_in/rs2_in/invalidate : issued by execute/hazard (master)
//   busy/done/result_out                       : returned by the unit (slave)
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      function_in;
  logic [XLEN-1:0] rs1_in;
  logic [XLEN-1:0] rs2_in;
  logic            invalidate;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result_out;

  modport master (
    output start, function_in, rs1_in, rs2_in, invalidate,
    input  busy, done, result_out
  );

  modport slave (
    input  start, function_in, rs1_in, rs2_in, invalidate,
    output busy, done, result_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32/64 M-extension multiply/divide.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : muldiv_unit_if.slave (start/function_in/rs1_in/rs2_in/invalidate in,
//              busy (combinational) / done (1-cycle pulse) / result_out (held) out)
// Operands are converted to magnitudes at accept, processed BITS_PER_CYCLE bits
// per CALC cycle, and sign-corrected in FINISH.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  muldiv_unit_if.slave bus
);
  localparam int N  = XLEN / BITS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t            state_q, state_d;
  logic [2:0]        func_q, func_d;
  logic              neg_q, neg_d;
  logic              special_q, special_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  // ---- accept-time decode ----
  logic [2:0]      fn;
  logic            sgn_a, sgn_b, a_neg, b_neg, is_div, div0, ovf, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  always_comb begin
    fn     = bus.function_in;
    // signed rs1: everything except MULHU/DIVU/REMU; rs2 additionally not MULHSU
    sgn_a  = ~(fn[0] & (fn[1] | fn[2]));
    sgn_b  = sgn_a & (fn != 3'b010);
    a_neg  = sgn_a & bus.rs1_in[XLEN-1];
    b_neg  = sgn_b & bus.rs2_in[XLEN-1];
    a_mag  = a_neg ? -bus.rs1_in : bus.rs1_in;
    b_mag  = b_neg ? -bus.rs2_in : bus.rs2_in;
    is_div = fn[2];
    div0   = is_div && (bus.rs2_in == '0);
    ovf    = is_div && !fn[0] && (bus.rs1_in == {1'b1, {(XLEN-1){1'b0}}})
             && (bus.rs2_in == '1);
    // fn[1] selects remainder for divides
    if (div0) spec_res = fn[1] ? bus.rs1_in : '1;
    else      spec_res = fn[1] ? '0 : bus.rs1_in;
    accept = (state_q == IDLE) && bus.start && !bus.invalidate && !done_q;
  end

  // ---- one CALC cycle: BITS_PER_CYCLE radix-2 steps chained ----
  // Multiply: acc = {partial, multiplier}, shift right, add multiplicand on lsb.
  // Divide:   acc = {remainder, dividend/quotient}, shift left, restoring subtract.
  logic [2*XLEN-1:0] step_acc;
  logic [XLEN:0]     sum, rem_sh, diff;

  always_comb begin
    step_acc = acc_q;
    sum      = '0;
    rem_sh   = '0;
    diff     = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (!func_q[2]) begin
        sum      = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opb_q} : '0);
        step_acc = {sum, step_acc[XLEN-1:1]};
      end else begin
        rem_sh = step_acc[2*XLEN-1:XLEN-1];
        diff   = rem_sh - {1'b0, opb_q};
        if (!diff[XLEN]) step_acc = {diff[XLEN-1:0], step_acc[XLEN-2:0], 1'b1};
        else             step_acc = {rem_sh[XLEN-1:0], step_acc[XLEN-2:0], 1'b0};
      end
    end
  end

  // ---- FINISH result select ----
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   div_val, fin;

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    div_val = func_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_val = neg_q ? -div_val : div_val;
    if (special_q)          fin = acc_q[XLEN-1:0];
    else if (func_q[2])     fin = div_val;
    else if (func_q == '0)  fin = prod[XLEN-1:0];
    else                    fin = prod[2*XLEN-1:XLEN];
  end

  // ---- next state ----
  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    neg_d     = neg_q;
    special_d = special_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          func_d = fn;
          // remainder takes the dividend sign, everything else the xor
          neg_d  = (fn[2] & fn[1]) ? a_neg : (a_neg ^ b_neg);
          opb_d  = b_mag;
          cnt_d  = CW'(N - 1);
          if (div0 || ovf) begin
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, spec_res};
            state_d   = FINISH;
          end else begin
            special_d = 1'b0;
            acc_d     = {{XLEN{1'b0}}, a_mag};
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        acc_d = step_acc;
        if (cnt_q == '0) state_d = FINISH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FINISH: begin
        done_d   = 1'b1;
        result_d = fin;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.invalidate) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      func_q    <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      neg_q     <= neg_d;
      special_q <= special_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  // drops in the done cycle so execute advances on that edge
  assign bus.busy       = (state_q != IDLE) || (bus.start && !done_q && !bus.invalidate);
  assign bus.done       = done_q;
  assign bus.result_out = result_q;
endmodule
